// File: rtl/mem_stage_access.sv
// MEM pipeline stage: drives a req/ack data-memory port for loads/stores, stalls upstream
// stages while the access is in flight, and registers the MEM/WB outputs.
module mem_stage_access #(
  parameter logic [31:0] BASE_ADDR = 32'd1024,
  parameter int unsigned ADDR_W    = 16,
  parameter int unsigned TIMEOUT   = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [31:0]       PC_in,
  input  logic [31:0]       ALU_result_in,
  input  logic [31:0]       ST_val_in,
  input  logic [4:0]        Dest_in,
  input  logic              MEM_R_EN_in,
  input  logic              MEM_W_EN_in,
  input  logic              WB_EN_in,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic              mem_ack,
  input  logic [31:0]       mem_rdata,
  output logic              freeze,
  output logic [31:0]       PC_out,
  output logic [31:0]       ALU_result,
  output logic [31:0]       MEM_result,
  output logic [4:0]        Dest,
  output logic              MEM_R_EN,
  output logic              WB_EN,
  output logic              mem_err
);

  // Counter only needs to reach TIMEOUT-1.
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_data;

  logic             w_op;
  logic [31:0]      w_offset;

  assign w_op     = MEM_R_EN_in | MEM_W_EN_in;
  assign w_offset = ALU_result_in - BASE_ADDR;

  // Gated by reset so the stall releases immediately while reset is held.
  assign freeze = rst & (((r_state == S_IDLE) & w_op) | (r_state == S_WAIT));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_cnt      <= '0;
      r_data     <= '0;
      mem_req    <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      PC_out     <= '0;
      ALU_result <= '0;
      MEM_result <= '0;
      Dest       <= '0;
      MEM_R_EN   <= 1'b0;
      WB_EN      <= 1'b0;
      mem_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_op) begin
            mem_addr  <= ADDR_W'(w_offset >> 2);
            mem_we    <= MEM_W_EN_in;
            mem_wdata <= ST_val_in;
            mem_req   <= 1'b1;
            r_cnt     <= '0;
            WB_EN     <= 1'b0;
            MEM_R_EN  <= 1'b0;
            r_state   <= S_WAIT;
          end else begin
            PC_out     <= PC_in;
            ALU_result <= ALU_result_in;
            Dest       <= Dest_in;
            MEM_R_EN   <= MEM_R_EN_in;
            WB_EN      <= WB_EN_in;
          end
        end
        S_WAIT: begin
          WB_EN    <= 1'b0;
          MEM_R_EN <= 1'b0;
          // Ack is checked first so it wins over a coincident timeout.
          if (mem_ack) begin
            mem_req <= 1'b0;
            r_data  <= mem_we ? 32'd0 : mem_rdata;
            r_state <= S_DONE;
          end else if (r_cnt == CNT_W'(TIMEOUT - 1)) begin
            mem_req <= 1'b0;
            mem_err <= 1'b1;
            r_data  <= '0;
            r_state <= S_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        S_DONE: begin
          PC_out     <= PC_in;
          ALU_result <= ALU_result_in;
          Dest       <= Dest_in;
          MEM_R_EN   <= MEM_R_EN_in;
          WB_EN      <= WB_EN_in;
          MEM_result <= r_data;
          r_state    <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule
